// File: rtl/layer_sequencer.sv
// Per-layer loop over output channel groups: configures conv_controller one group
// at a time, issues go, and paces groups on pixel-source readiness and output flush.
`timescale 1ns/1ps
module layer_sequencer #(
    parameter int WT_ADDR_WIDTH   = 12,
    parameter int BIAS_ADDR_WIDTH = 7,
    parameter int CI_WIDTH        = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CI_WIDTH-1:0]        cfg_ci_groups,
    input  logic [BIAS_ADDR_WIDTH:0]   cfg_co_groups,
    input  logic [BIAS_ADDR_WIDTH-1:0] cfg_og_base,
    input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base,
    output logic                       busy,
    output logic                       layer_done,
    output logic                       cfg_err,
    output logic [CI_WIDTH-1:0]        conv_ci_groups,
    output logic [BIAS_ADDR_WIDTH-1:0] conv_output_group,
    output logic [WT_ADDR_WIDTH-1:0]   conv_wt_base_addr,
    output logic                       conv_go,
    input  logic                       conv_done,
    output logic                       src_restart,
    input  logic                       src_ready,
    input  logic                       out_flush_done,
    output logic [BIAS_ADDR_WIDTH:0]   og_index
);

    typedef enum logic [2:0] {IDLE, ISSUE, RUN, FLUSH, NEXT, FIN} state_t;

    state_t                     state_reg;
    logic [BIAS_ADDR_WIDTH:0]   co_groups_reg;
    logic                       err_reg;
    logic                       flush_seen_reg;
    logic [BIAS_ADDR_WIDTH:0]   og_index_next;

    assign og_index_next = og_index + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            co_groups_reg     <= '0;
            err_reg           <= 1'b0;
            flush_seen_reg    <= 1'b0;
            busy              <= 1'b0;
            layer_done        <= 1'b0;
            cfg_err           <= 1'b0;
            conv_go           <= 1'b0;
            src_restart       <= 1'b0;
            conv_ci_groups    <= '0;
            conv_output_group <= '0;
            conv_wt_base_addr <= '0;
            og_index          <= '0;
        end else begin
            conv_go     <= 1'b0;
            src_restart <= 1'b0;
            layer_done  <= 1'b0;
            cfg_err     <= 1'b0;

            case (state_reg)
                IDLE: begin
                    flush_seen_reg <= 1'b0;
                    if (start) begin
                        busy          <= 1'b1;
                        co_groups_reg <= cfg_co_groups;
                        if (cfg_co_groups == '0 || cfg_ci_groups == '0) begin
                            err_reg   <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            err_reg           <= 1'b0;
                            conv_ci_groups    <= cfg_ci_groups;
                            conv_output_group <= cfg_og_base;
                            conv_wt_base_addr <= cfg_wt_base;
                            og_index          <= '0;
                            state_reg         <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (src_ready) begin
                        conv_go     <= 1'b1;
                        src_restart <= 1'b1;
                        state_reg   <= RUN;
                    end
                end

                RUN: begin
                    // The writer may finish before or alongside done; remember it.
                    if (out_flush_done)
                        flush_seen_reg <= 1'b1;
                    if (conv_done)
                        state_reg <= FLUSH;
                end

                FLUSH: begin
                    if (flush_seen_reg || out_flush_done) begin
                        flush_seen_reg <= 1'b0;
                        state_reg      <= NEXT;
                    end
                end

                NEXT: begin
                    og_index          <= og_index_next;
                    conv_output_group <= conv_output_group + 1'b1;
                    conv_wt_base_addr <= conv_wt_base_addr + WT_ADDR_WIDTH'(conv_ci_groups);
                    state_reg         <= (og_index_next == co_groups_reg) ? FIN : ISSUE;
                end

                FIN: begin
                    layer_done <= 1'b1;
                    cfg_err    <= err_reg;
                    err_reg    <= 1'b0;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: acts as conv_controller, pixel source and
// output writer, checking per-group configuration, pulse counts and layer end.
`timescale 1ns/1ps
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  cfg_ci_groups = '0;
    logic [7:0]  cfg_co_groups = '0;
    logic [6:0]  cfg_og_base = '0;
    logic [11:0] cfg_wt_base = '0;
    logic        busy, layer_done, cfg_err, conv_go, src_restart;
    logic [9:0]  conv_ci_groups;
    logic [6:0]  conv_output_group;
    logic [11:0] conv_wt_base_addr;
    logic        conv_done = 1'b0;
    logic        src_ready = 1'b0;
    logic        out_flush_done = 1'b0;
    logic [7:0]  og_index;

    int tests = 0;
    int fails = 0;
    int go_cnt = 0, rs_cnt = 0, ld_cnt = 0;
    int g0, r0, l0;

    layer_sequencer #(.WT_ADDR_WIDTH(12), .BIAS_ADDR_WIDTH(7), .CI_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_ci_groups(cfg_ci_groups), .cfg_co_groups(cfg_co_groups),
        .cfg_og_base(cfg_og_base), .cfg_wt_base(cfg_wt_base),
        .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err),
        .conv_ci_groups(conv_ci_groups), .conv_output_group(conv_output_group),
        .conv_wt_base_addr(conv_wt_base_addr), .conv_go(conv_go),
        .conv_done(conv_done), .src_restart(src_restart), .src_ready(src_ready),
        .out_flush_done(out_flush_done), .og_index(og_index)
    );

    always #5 clk = ~clk;

    // Pulse counters: each counts the pulse visible during the preceding cycle.
    always @(posedge clk) begin
        if (conv_go)     go_cnt <= go_cnt + 1;
        if (src_restart) rs_cnt <= rs_cnt + 1;
        if (layer_done)  ld_cnt <= ld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_layer(input logic [9:0] ci, input logic [7:0] co,
                               input logic [6:0] ogb, input logic [11:0] wtb);
        @(negedge clk);
        cfg_ci_groups = ci; cfg_co_groups = co; cfg_og_base = ogb; cfg_wt_base = wtb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // fmode 0: flush one cycle after done; 1: flush with done; 2: flush early in RUN
    task automatic do_group(input logic [6:0] eog, input logic [11:0] ewt,
                            input int stall, input int fmode);
        int gs;
        bit seen;
        gs = go_cnt;
        repeat (stall) @(negedge clk);
        if (stall > 0) check("no_go_while_not_ready", go_cnt - gs, 0);
        src_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (conv_go) seen = 1'b1;
        end
        check("go_seen", {31'd0, seen}, 1);
        check("conv_output_group", conv_output_group, eog);
        check("conv_wt_base_addr", conv_wt_base_addr, ewt);
        check("src_restart_with_go", src_restart, 1);
        src_ready = 1'b0;
        case (fmode)
            0: begin
                conv_done = 1'b1;
                @(negedge clk); conv_done = 1'b0; out_flush_done = 1'b1;
                @(negedge clk); out_flush_done = 1'b0;
            end
            1: begin
                conv_done = 1'b1; out_flush_done = 1'b1;
                @(negedge clk); conv_done = 1'b0; out_flush_done = 1'b0;
            end
            default: begin
                out_flush_done = 1'b1;
                @(negedge clk); out_flush_done = 1'b0;
                repeat (2) @(negedge clk);
                conv_done = 1'b1;
                @(negedge clk); conv_done = 1'b0;
            end
        endcase
    endtask

    task automatic wait_layer_done(input logic [7:0] eidx, input logic eerr, input int ld0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (layer_done) seen = 1'b1;
        end
        check("layer_done_seen", {31'd0, seen}, 1);
        check("og_index_at_done", og_index, eidx);
        check("cfg_err_at_done", cfg_err, eerr);
        check("busy_low_at_done", busy, 0);
        @(negedge clk);
        check("single_layer_done", ld_cnt - ld0, 1);
        check("layer_done_one_cycle", layer_done, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_conv_go", conv_go, 0);
        check("rst_src_restart", src_restart, 0);
        check("rst_og_index", og_index, 0);
        check("rst_output_group", conv_output_group, 0);
        check("rst_wt_base", conv_wt_base_addr, 0);
        check("rst_ci_groups", conv_ci_groups, 0);
        rst = 1'b0;

        // Basic 4-group layer
        g0 = go_cnt; r0 = rs_cnt; l0 = ld_cnt;
        start_layer(10'd16, 8'd4, 7'd5, 12'd100);
        check("conv_ci_groups", conv_ci_groups, 16);
        do_group(7'd5, 12'd100, 0, 0);
        do_group(7'd6, 12'd116, 0, 0);
        do_group(7'd7, 12'd132, 0, 0);
        do_group(7'd8, 12'd148, 0, 0);
        wait_layer_done(8'd4, 1'b0, l0);
        check("basic_go_count", go_cnt - g0, 4);
        check("basic_restart_count", rs_cnt - r0, 4);

        // Ready stalls plus coincident and early flush
        g0 = go_cnt; l0 = ld_cnt;
        start_layer(10'd16, 8'd4, 7'd5, 12'd100);
        do_group(7'd5, 12'd100, 20, 1);
        do_group(7'd6, 12'd116, 20, 2);
        do_group(7'd7, 12'd132, 20, 0);
        do_group(7'd8, 12'd148, 20, 1);
        wait_layer_done(8'd4, 1'b0, l0);
        check("stall_go_count", go_cnt - g0, 4);

        // Zero output-group count
        g0 = go_cnt; r0 = rs_cnt; l0 = ld_cnt;
        start_layer(10'd16, 8'd0, 7'd5, 12'd100);
        check("zero_co_no_early_done", layer_done, 0);
        @(negedge clk);
        check("zero_co_layer_done", layer_done, 1);
        check("zero_co_cfg_err", cfg_err, 1);
        check("zero_co_busy", busy, 0);
        @(negedge clk);
        check("zero_co_err_one_cycle", cfg_err, 0);
        check("zero_co_go_count", go_cnt - g0, 0);
        check("zero_co_restart_count", rs_cnt - r0, 0);

        // Zero input-group count
        g0 = go_cnt; l0 = ld_cnt;
        start_layer(10'd0, 8'd4, 7'd5, 12'd100);
        @(negedge clk);
        check("zero_ci_layer_done", layer_done, 1);
        check("zero_ci_cfg_err", cfg_err, 1);
        @(negedge clk);
        check("zero_ci_go_count", go_cnt - g0, 0);
        check("zero_ci_done_count", ld_cnt - l0, 1);

        // Address and group wrap
        l0 = ld_cnt;
        start_layer(10'd4, 8'd3, 7'd126, 12'd4090);
        do_group(7'd126, 12'd4090, 0, 0);
        do_group(7'd127, 12'd4094, 0, 0);
        do_group(7'd0,   12'd2,    0, 0);
        wait_layer_done(8'd3, 1'b0, l0);

        // Start while busy is ignored
        g0 = go_cnt; l0 = ld_cnt;
        start_layer(10'd16, 8'd4, 7'd5, 12'd100);
        do_group(7'd5, 12'd100, 0, 0);
        cfg_ci_groups = 10'd3; cfg_co_groups = 8'd2; cfg_og_base = 7'd50; cfg_wt_base = 12'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_group(7'd6, 12'd116, 2, 0);
        do_group(7'd7, 12'd132, 0, 1);
        do_group(7'd8, 12'd148, 0, 0);
        wait_layer_done(8'd4, 1'b0, l0);
        check("busy_start_go_count", go_cnt - g0, 4);

        // Reset during RUN of group 2
        l0 = ld_cnt;
        start_layer(10'd16, 8'd4, 7'd5, 12'd100);
        do_group(7'd5, 12'd100, 0, 0);
        begin
            bit seen;
            seen = 1'b0;
            src_ready = 1'b1;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (conv_go) seen = 1'b1;
            end
            check("rst_test_go2_seen", {31'd0, seen}, 1);
            check("rst_test_group2", conv_output_group, 6);
            src_ready = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_output_group", conv_output_group, 0);
        check("midrst_wt_base", conv_wt_base_addr, 0);
        check("midrst_og_index", og_index, 0);
        check("midrst_conv_go", conv_go, 0);
        g0 = go_cnt; r0 = rs_cnt;
        conv_done = 1'b1; out_flush_done = 1'b1; src_ready = 1'b1;
        repeat (10) @(negedge clk);
        conv_done = 1'b0; out_flush_done = 1'b0; src_ready = 1'b0;
        check("midrst_no_go", go_cnt - g0, 0);
        check("midrst_no_restart", rs_cnt - r0, 0);
        check("midrst_no_layer_done", ld_cnt - l0, 0);

        // Fresh layer after reset
        g0 = go_cnt; l0 = ld_cnt;
        start_layer(10'd16, 8'd4, 7'd5, 12'd100);
        do_group(7'd5, 12'd100, 0, 0);
        do_group(7'd6, 12'd116, 0, 2);
        do_group(7'd7, 12'd132, 0, 0);
        do_group(7'd8, 12'd148, 0, 1);
        wait_layer_done(8'd4, 1'b0, l0);
        check("fresh_go_count", go_cnt - g0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Drives the per-layer loop over output channel groups for the convolution engine. It configures conv_controller for one output group at a time, pulses go, and waits for done. Between groups it waits for the pixel source to be ready to replay the image and for the output writer to flush. It sits between the layer descriptor (host/register file) and conv_controller, the pixel source and the output writer.

Parameters:
WT_ADDR_WIDTH, 12, weight-memory address width (matches conv_controller).
BIAS_ADDR_WIDTH, 7, output-group / bias-group index width.
CI_WIDTH, 10, width of the input-channel-group count.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a layer; sampled only in IDLE
cfg_ci_groups  in  CI_WIDTH  input channel groups per output group
cfg_co_groups  in  BIAS_ADDR_WIDTH+1  number of output groups in the layer
cfg_og_base  in  BIAS_ADDR_WIDTH  first bias/output group index
cfg_wt_base  in  WT_ADDR_WIDTH  weight address of group 0
busy  out  1  layer in progress
layer_done  out  1  one-cycle pulse at end of layer
cfg_err  out  1  one-cycle pulse, with layer_done, when a zero count is rejected
conv_ci_groups  out  CI_WIDTH  to conv_controller cfg_ci_groups
conv_output_group  out  BIAS_ADDR_WIDTH  to conv_controller cfg_output_group
conv_wt_base_addr  out  WT_ADDR_WIDTH  to conv_controller cfg_wt_base_addr
conv_go  out  1  one-cycle start pulse to conv_controller
conv_done  in  1  conv_controller done pulse
src_restart  out  1  one-cycle pulse: pixel source rewinds to pixel 0
src_ready  in  1  pixel source able to stream from pixel 0
out_flush_done  in  1  output writer finished current group (pulse)
og_index  out  BIAS_ADDR_WIDTH+1  groups completed so far in this layer

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, rst on clk.
- Reset values: state IDLE. busy, layer_done, cfg_err, conv_go and src_restart are 0. conv_ci_groups, conv_output_group, conv_wt_base_addr and og_index are 0.
- States: IDLE, ISSUE, RUN, FLUSH, NEXT, FIN.
- IDLE: when start=1 at edge N, latch all cfg_* inputs. busy=1 from N+1.
  - If cfg_co_groups==0 or cfg_ci_groups==0: go to FIN with the cfg_err flag set.
  - Otherwise: load conv_output_group=cfg_og_base, conv_wt_base_addr=cfg_wt_base, conv_ci_groups=cfg_ci_groups and og_index=0, then go to ISSUE.
- ISSUE: wait for src_ready=1. On the edge that samples it high, conv_go=1 and src_restart=1 for exactly one cycle, then go to RUN. While src_ready=0, hold in ISSUE indefinitely.
- RUN: wait for conv_done. Also capture out_flush_done into a sticky flush_seen flag, because the flush may coincide with or precede done. On conv_done go to FLUSH.
- FLUSH: if flush_seen is set or out_flush_done=1, go to NEXT. Clear flush_seen on leaving.
- NEXT (1 cycle):
  - og_index += 1.
  - conv_output_group += 1, wrapping modulo 2^BIAS_ADDR_WIDTH.
  - conv_wt_base_addr += conv_ci_groups, wrapping modulo 2^WT_ADDR_WIDTH. Use accumulation, no multiplier.
  - If the new og_index == latched co_groups, go to FIN; else go to ISSUE.
- FIN (1 cycle): layer_done=1, cfg_err=flag. Next cycle: busy=0, state IDLE, flag cleared.
- conv_* cfg outputs are stable from ISSUE entry until NEXT for each group. conv_controller samples them at go.
- start while busy is ignored; the latched configuration is never altered mid-layer.
- conv_done outside RUN is ignored. out_flush_done outside RUN/FLUSH is ignored.
- Minimum spacing between consecutive conv_go pulses is 4 cycles (RUN, FLUSH, NEXT, ISSUE), assuming immediate done, flush and ready.
- rst mid-layer: return to reset values on the next edge. No layer_done is emitted, and no conv_go or src_restart is issued after rst is sampled.

Test Plan:
- Basic layer: ci=16, co=4, og_base=5, wt_base=100, src_ready=1, flush one cycle after done -> 4 conv_go pulses.
  - conv_output_group 5,6,7,8; conv_wt_base_addr 100,116,132,148.
  - Exactly 4 src_restart pulses, one layer_done, og_index=4 at layer_done, cfg_err=0.
- Handshake stalls: hold src_ready=0 for 20 cycles before each group -> no conv_go until src_ready; still exactly one go per group. out_flush_done arriving in the same cycle as conv_done, and also earlier during RUN -> no hang, next group issued.
- Zero counts: co=0 -> no conv_go/src_restart, layer_done and cfg_err pulse together 2 cycles after start. ci=0 -> same.
- Wrap: WT_ADDR_WIDTH=12, wt_base=4090, ci=4, co=3 -> bases 4090, 4094, 2. og_base=126, BIAS_ADDR_WIDTH=7 -> groups 126, 127, 0.
- Start while busy: pulse start with different cfg mid-layer -> ignored; addresses follow the original cfg; single layer_done.
- Reset in RUN during group 2 -> all outputs at reset values the next cycle, no further go/layer_done. A fresh start then runs a full 4-group layer correctly.
